// File: rtl/exception_trap_sequencer.sv
// Picks the oldest reported exception, latches cause/epc/tval, then sequences
// flush -> redirect -> trap residency -> return, locking up on a nested fault.
module exception_trap_sequencer #(
  parameter int N_STAGES     = 2,
  parameter int XLEN         = 32,
  parameter int CODE_W       = 4,
  parameter int NO_E_CODE    = 0,
  parameter int ECALL_CODE   = 11,
  parameter int FLUSH_CYCLES = 2,
  parameter int VECTORED     = 0,
  parameter int COUNT_W      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_STAGES*CODE_W-1:0] i_exc_code,
  input  logic [N_STAGES*XLEN-1:0]   i_exc_pc,
  input  logic [N_STAGES*XLEN-1:0]   i_exc_tval,
  input  logic [XLEN-1:0]            i_trap_base,
  input  logic                       i_mret,
  input  logic                       i_redirect_ready,
  output logic [N_STAGES-1:0]        o_flush,
  output logic                       o_redirect_valid,
  output logic [XLEN-1:0]            o_redirect_pc,
  output logic                       o_trap_permission,
  output logic [CODE_W-1:0]          o_cause,
  output logic [XLEN-1:0]            o_epc,
  output logic [XLEN-1:0]            o_tval,
  output logic [COUNT_W-1:0]         o_exc_count,
  output logic                       o_double_fault
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_IN_TRAP,
    ST_RETURN,
    ST_LOCK
  } state_t;

  state_t state, state_next;

  logic [N_STAGES-1:0] hit;
  logic                any_hit;
  logic [CODE_W-1:0]   win_code;
  logic [XLEN-1:0]     win_pc;
  logic [XLEN-1:0]     win_tval;

  logic [FC_W-1:0]     flush_cnt;
  logic [CODE_W-1:0]   cause;
  logic [XLEN-1:0]     epc;
  logic [XLEN-1:0]     tval;
  logic [COUNT_W-1:0]  exc_count;
  logic                double_fault;
  logic [XLEN-1:0]     redirect_pc;

  logic                capture;
  logic                load_vector;
  logic                load_return;
  logic                set_double_fault;
  logic [XLEN-1:0]     base_aligned;
  logic [XLEN-1:0]     vector_pc;
  logic [XLEN-1:0]     return_pc;

  // Later iterations overwrite earlier ones, so the oldest (highest index) hit wins.
  always_comb begin
    hit      = '0;
    win_code = CODE_W'(NO_E_CODE);
    win_pc   = '0;
    win_tval = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      hit[k] = (i_exc_code[k*CODE_W +: CODE_W] != CODE_W'(NO_E_CODE));
      if (hit[k]) begin
        win_code = i_exc_code[k*CODE_W +: CODE_W];
        win_pc   = i_exc_pc[k*XLEN +: XLEN];
        win_tval = i_exc_tval[k*XLEN +: XLEN];
      end
    end
  end

  assign any_hit = |hit;

  assign base_aligned = i_trap_base & ~XLEN'(3);
  assign vector_pc    = (VECTORED != 0) ? base_aligned + (XLEN'(cause) << 2) : base_aligned;
  assign return_pc    = (cause == CODE_W'(ECALL_CODE)) ? epc + XLEN'(4) : epc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    capture          = 1'b0;
    load_vector      = 1'b0;
    load_return      = 1'b0;
    set_double_fault = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_hit) begin
          capture    = 1'b1;
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) begin
          load_vector = 1'b1;
          state_next  = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (i_redirect_ready) begin
          state_next = ST_IN_TRAP;
        end
      end
      // A fault inside the handler outranks a simultaneous mret.
      ST_IN_TRAP: begin
        if (any_hit) begin
          set_double_fault = 1'b1;
          state_next       = ST_LOCK;
        end else if (i_mret) begin
          load_return = 1'b1;
          state_next  = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (i_redirect_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCK: begin
        state_next = ST_LOCK;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The redirect target is registered on entry so it stays stable while fetch stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_cnt    <= '0;
      cause        <= CODE_W'(NO_E_CODE);
      epc          <= '0;
      tval         <= '0;
      exc_count    <= '0;
      double_fault <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      if (capture) begin
        cause     <= win_code;
        epc       <= win_pc;
        tval      <= win_tval;
        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        if (exc_count != {COUNT_W{1'b1}}) begin
          exc_count <= exc_count + COUNT_W'(1);
        end
      end else if (state == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
      if (load_vector) begin
        redirect_pc <= vector_pc;
      end else if (load_return) begin
        redirect_pc <= return_pc;
      end
      if (set_double_fault) begin
        double_fault <= 1'b1;
      end
    end
  end

  assign o_flush           = (state == ST_FLUSH || state == ST_LOCK) ? {N_STAGES{1'b1}} : '0;
  assign o_redirect_valid  = (state == ST_REDIRECT || state == ST_RETURN);
  assign o_redirect_pc     = redirect_pc;
  assign o_trap_permission = (state == ST_IN_TRAP || state == ST_RETURN);
  assign o_cause           = cause;
  assign o_epc             = epc;
  assign o_tval            = tval;
  assign o_exc_count       = exc_count;
  assign o_double_fault    = double_fault;

endmodule

// File: tb/tb_exception_trap_sequencer.sv
// Self-checking bench: three instances (default, vectored, 2-bit counter) share stimulus;
// table vectors, randomized transactions against a model, and hand-written corner cases.
module tb_exception_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  exc_code;
  logic [63:0] exc_pc;
  logic [63:0] exc_tval;
  logic [31:0] trap_base;
  logic        mret;
  logic        redirect_ready;

  logic [1:0]  flush_a, flush_v, flush_s;
  logic        rv_a, rv_v, rv_s;
  logic [31:0] rpc_a, rpc_v, rpc_s;
  logic        perm_a, perm_v, perm_s;
  logic [3:0]  cause_a, cause_v, cause_s;
  logic [31:0] epc_a, epc_v, epc_s;
  logic [31:0] tval_a, tval_v, tval_s;
  logic [7:0]  cnt_a, cnt_v;
  logic [1:0]  cnt_s;
  logic        df_a, df_v, df_s;

  int checks;
  int passes;
  int model_count;

  typedef struct {
    logic [3:0]  code0;
    logic [3:0]  code1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] tval0;
    logic [31:0] tval1;
    logic [31:0] base;
    int          stall;
    logic [3:0]  exp_cause;
    logic [31:0] exp_epc;
    logic [31:0] exp_tval;
    logic [31:0] exp_pc;
    logic [31:0] exp_vec_pc;
    logic [31:0] exp_ret_pc;
  } vec_t;

  vec_t tbl [6];

  exception_trap_sequencer dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_tval(exc_tval), .i_trap_base(trap_base), .i_mret(mret),
    .i_redirect_ready(redirect_ready), .o_flush(flush_a), .o_redirect_valid(rv_a),
    .o_redirect_pc(rpc_a), .o_trap_permission(perm_a), .o_cause(cause_a), .o_epc(epc_a),
    .o_tval(tval_a), .o_exc_count(cnt_a), .o_double_fault(df_a)
  );

  exception_trap_sequencer #(.VECTORED(1)) dut_v (
    .i_clk(clk), .i_rst_n(rst_n), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_tval(exc_tval), .i_trap_base(trap_base), .i_mret(mret),
    .i_redirect_ready(redirect_ready), .o_flush(flush_v), .o_redirect_valid(rv_v),
    .o_redirect_pc(rpc_v), .o_trap_permission(perm_v), .o_cause(cause_v), .o_epc(epc_v),
    .o_tval(tval_v), .o_exc_count(cnt_v), .o_double_fault(df_v)
  );

  exception_trap_sequencer #(.COUNT_W(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_tval(exc_tval), .i_trap_base(trap_base), .i_mret(mret),
    .i_redirect_ready(redirect_ready), .o_flush(flush_s), .o_redirect_valid(rv_s),
    .o_redirect_pc(rpc_s), .o_trap_permission(perm_s), .o_cause(cause_s), .o_epc(epc_s),
    .o_tval(tval_s), .o_exc_count(cnt_s), .o_double_fault(df_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    checkOutput("count_default", {56'd0, cnt_a}, (model_count > 255) ? 64'd255 : 64'(model_count));
    checkOutput("count_sat2", {62'd0, cnt_s}, (model_count > 3) ? 64'd3 : 64'(model_count));
  endtask

  // Expected results straight from the selection/redirect rules, for random transactions.
  function automatic vec_t fill_expected(input vec_t v);
    vec_t r = v;
    if (v.code1 != 4'd0) begin
      r.exp_cause = v.code1; r.exp_epc = v.pc1; r.exp_tval = v.tval1;
    end else begin
      r.exp_cause = v.code0; r.exp_epc = v.pc0; r.exp_tval = v.tval0;
    end
    r.exp_pc     = v.base & 32'hFFFF_FFFC;
    r.exp_vec_pc = r.exp_pc + 32'(r.exp_cause) * 32'd4;
    r.exp_ret_pc = r.exp_epc + ((r.exp_cause == 4'd11) ? 32'd4 : 32'd0);
    return r;
  endfunction

  // One full trap: capture, flush, (stalled) redirect, handler, mret, return.
  task automatic applyStimulus(input vec_t v);
    exc_code = {v.code1, v.code0};
    exc_pc = {v.pc1, v.pc0};
    exc_tval = {v.tval1, v.tval0};
    trap_base = v.base;
    redirect_ready = 1'b0;
    mret = 1'b0;
    step();
    model_count++;
    checkOutput("flush_cycle1", {62'd0, flush_a}, 64'h3);
    checkOutput("valid_in_flush", {63'd0, rv_a}, 64'd0);
    checkOutput("cause", {60'd0, cause_a}, {60'd0, v.exp_cause});
    checkOutput("epc", {32'd0, epc_a}, {32'd0, v.exp_epc});
    checkOutput("tval", {32'd0, tval_a}, {32'd0, v.exp_tval});
    check_counts();
    exc_code = 8'h97;
    step();
    checkOutput("flush_cycle2", {62'd0, flush_a}, 64'h3);
    checkOutput("valid_in_flush2", {63'd0, rv_a}, 64'd0);
    step();
    checkOutput("flush_after", {62'd0, flush_a}, 64'd0);
    checkOutput("redirect_valid", {63'd0, rv_a}, 64'd1);
    checkOutput("redirect_pc", {32'd0, rpc_a}, {32'd0, v.exp_pc});
    checkOutput("redirect_pc_vec", {32'd0, rpc_v}, {32'd0, v.exp_vec_pc});
    checkOutput("cause_held_flush", {60'd0, cause_a}, {60'd0, v.exp_cause});
    trap_base = ~v.base;
    for (int i = 0; i < v.stall; i++) begin
      step();
      checkOutput("stall_valid", {63'd0, rv_a}, 64'd1);
      checkOutput("stall_pc", {32'd0, rpc_a}, {32'd0, v.exp_pc});
      checkOutput("stall_pc_vec", {32'd0, rpc_v}, {32'd0, v.exp_vec_pc});
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    exc_code = 8'h00;
    checkOutput("perm_in_trap", {63'd0, perm_a}, 64'd1);
    checkOutput("valid_in_trap", {63'd0, rv_a}, 64'd0);
    checkOutput("flush_in_trap", {62'd0, flush_a}, 64'd0);
    step();
    checkOutput("perm_in_trap2", {63'd0, perm_a}, 64'd1);
    mret = 1'b1;
    step();
    mret = 1'b0;
    checkOutput("return_valid", {63'd0, rv_a}, 64'd1);
    checkOutput("return_pc", {32'd0, rpc_a}, {32'd0, v.exp_ret_pc});
    checkOutput("return_pc_vec", {32'd0, rpc_v}, {32'd0, v.exp_ret_pc});
    checkOutput("perm_in_return", {63'd0, perm_a}, 64'd1);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checkOutput("perm_idle", {63'd0, perm_a}, 64'd0);
    checkOutput("valid_idle", {63'd0, rv_a}, 64'd0);
    checkOutput("no_double_fault", {63'd0, df_a}, 64'd0);
  endtask

  initial begin
    vec_t rv;
    checks = 0;
    passes = 0;
    model_count = 0;
    rst_n = 1'b0;
    exc_code = '0;
    exc_pc = '0;
    exc_tval = '0;
    trap_base = '0;
    mret = 1'b0;
    redirect_ready = 1'b0;

    tbl[0] = '{4'd2, 4'd0, 32'h0008_0010, 32'h0, 32'h0000_DEAD, 32'h0, 32'h0000_0100, 0,
               4'd2, 32'h0008_0010, 32'h0000_DEAD, 32'h0000_0100, 32'h0000_0108, 32'h0008_0010};
    tbl[1] = '{4'd2, 4'd4, 32'h0000_1000, 32'h0000_2000, 32'h11, 32'h22, 32'h0000_0100, 0,
               4'd4, 32'h0000_2000, 32'h22, 32'h0000_0100, 32'h0000_0110, 32'h0000_2000};
    tbl[2] = '{4'd0, 4'd11, 32'h0, 32'h0008_0040, 32'h0, 32'h0, 32'h0000_0200, 1,
               4'd11, 32'h0008_0040, 32'h0, 32'h0000_0200, 32'h0000_022C, 32'h0008_0044};
    tbl[3] = '{4'd5, 4'd0, 32'h0008_0040, 32'h0, 32'h55, 32'h0, 32'h0000_0200, 0,
               4'd5, 32'h0008_0040, 32'h55, 32'h0000_0200, 32'h0000_0214, 32'h0008_0040};
    tbl[4] = '{4'd3, 4'd0, 32'h0000_0300, 32'h0, 32'h33, 32'h0, 32'h0000_0103, 3,
               4'd3, 32'h0000_0300, 32'h33, 32'h0000_0100, 32'h0000_010C, 32'h0000_0300};
    tbl[5] = '{4'd11, 4'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 2,
               4'd11, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 32'h0000_002C, 32'h0000_0000};

    #12;
    checkOutput("reset_flush", {62'd0, flush_a}, 64'd0);
    checkOutput("reset_valid", {63'd0, rv_a}, 64'd0);
    checkOutput("reset_perm", {63'd0, perm_a}, 64'd0);
    checkOutput("reset_cause", {60'd0, cause_a}, 64'd0);
    checkOutput("reset_count", {56'd0, cnt_a}, 64'd0);
    checkOutput("reset_df", {63'd0, df_a}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] mret while idle");
    mret = 1'b1;
    step();
    mret = 1'b0;
    checkOutput("idle_mret_perm", {63'd0, perm_a}, 64'd0);
    checkOutput("idle_mret_valid", {63'd0, rv_a}, 64'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
    end

    $display("[TB] randomized transactions");
    for (int r = 0; r < 20; r++) begin
      rv.code0 = 4'($urandom_range(0, 15));
      rv.code1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (rv.code0 == 4'd0 && rv.code1 == 4'd0) rv.code0 = 4'd1;
      rv.pc0 = $urandom();
      rv.pc1 = $urandom();
      rv.tval0 = $urandom();
      rv.tval1 = $urandom();
      rv.base = $urandom();
      rv.stall = int'($urandom_range(0, 3));
      applyStimulus(fill_expected(rv));
    end

    $display("[TB] reset during redirect");
    exc_code = 8'h05;
    exc_pc = {32'h0, 32'h0000_5000};
    trap_base = 32'h0000_0400;
    step();
    model_count++;
    exc_code = 8'h00;
    step();
    step();
    checkOutput("pre_reset_valid", {63'd0, rv_a}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {63'd0, rv_a}, 64'd0);
    checkOutput("async_pc", {32'd0, rpc_a}, 64'd0);
    checkOutput("async_epc", {32'd0, epc_a}, 64'd0);
    checkOutput("async_cause", {60'd0, cause_a}, 64'd0);
    checkOutput("async_flush", {62'd0, flush_a}, 64'd0);
    model_count = 0;
    check_counts();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("redirect_dropped", {63'd0, rv_a}, 64'd0);

    $display("[TB] fault inside handler");
    exc_code = 8'h06;
    exc_pc = {32'h0, 32'h0000_4000};
    step();
    model_count++;
    exc_code = 8'h00;
    step();
    step();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checkOutput("df_pre_perm", {63'd0, perm_a}, 64'd1);
    exc_code = 8'h01;
    exc_pc = '1;
    mret = 1'b1;
    step();
    exc_code = 8'h00;
    mret = 1'b0;
    checkOutput("double_fault", {63'd0, df_a}, 64'd1);
    checkOutput("lock_valid", {63'd0, rv_a}, 64'd0);
    checkOutput("lock_perm", {63'd0, perm_a}, 64'd0);
    checkOutput("lock_cause", {60'd0, cause_a}, 64'd6);
    checkOutput("lock_epc", {32'd0, epc_a}, 64'h4000);
    check_counts();
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("lock_flush", {62'd0, flush_a}, 64'h3);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("lock_reset_flush", {62'd0, flush_a}, 64'd0);
    checkOutput("lock_reset_df", {63'd0, df_a}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
